timer_device: RTL and testbench
===============================

TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge system clock.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high.
REQ-004 Port Addr SHALL be: input, [3:2], word select; 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
REQ-005 Port WE SHALL be: input, 1 bit, register write enable for the current cycle.
REQ-006 Port Din SHALL be: input, 32 bits, write data.
REQ-007 Port Dout SHALL be: output, 32 bits, combinational read data for Addr.
REQ-008 Port IRQ SHALL be: output, 1 bit, interrupt request; drives one HWInt line of the CP0.
REQ-009 Parameter IDLE/LOAD/CNT/INT state encodings SHALL be: default 0/1/2/3, FSM state codes.

Function
REQ-010 CTRL SHALL hold these fields: [0] Enable; [2:1] Mode (00 = one-shot, 01 = auto-reload, 1x treated as 00); [3] IM, the interrupt mask.
- Bits [31:4] SHALL read 0.
REQ-011 A write with Addr=0 SHALL load CTRL[3:0] from Din[3:0] at the clock edge.
REQ-012 A write with Addr=1 SHALL load the 32-bit PRESET.
- A write with Addr=2 or Addr=3 SHALL be ignored.
REQ-013 Dout SHALL return:
- Addr=0: {28'b0, CTRL[3:0]}
- Addr=1: PRESET
- Addr=2: COUNT
- Addr=3: 0
REQ-014 The FSM SHALL make these transitions:
- IDLE: go to LOAD when Enable=1.
- LOAD: COUNT<=PRESET, then go to CNT.
- CNT: if Enable=0, go to IDLE with COUNT held. Else if COUNT>1, decrement COUNT. Else (COUNT is 1 or 0), set COUNT<=0 and irq_flag<=1, then go to INT.
- INT, one-shot mode: Enable<=0, then go to IDLE, with irq_flag held.
- INT, auto-reload mode: irq_flag<=0, then go to LOAD.
REQ-015 IRQ SHALL equal IM AND irq_flag, with no register stage.
REQ-016 Latency: with PRESET=N≥1, a CTRL write with Enable=1 at edge E0 SHALL produce:
- state LOAD after E1;
- COUNT=N in CNT after E2;
- COUNT=0, state INT and irq_flag=1 after E(2+N).
REQ-017 In auto-reload mode, the period SHALL be N+2 cycles, and IRQ SHALL be high for exactly 1 cycle per period (when IM=1).
REQ-018 In one-shot mode, irq_flag SHALL remain 1 until any write to CTRL or PRESET, which clears it at that edge.
REQ-019 A PRESET write during CNT SHALL NOT alter COUNT; the new value takes effect at the next LOAD.
REQ-020 If a software CTRL write and the INT-state one-shot Enable clear occur in the same cycle, the software write SHALL win.
REQ-021 Clearing Enable during LOAD SHALL let LOAD complete, then go to IDLE from CNT on the next edge.
REQ-022 Clearing IM SHALL mask IRQ without clearing irq_flag.
- Setting IM again while irq_flag=1 SHALL re-assert IRQ combinationally.
REQ-023 COUNT SHALL never wrap below 0.
REQ-024 When PRESET=0, the FSM SHALL go CNT to INT on the first CNT edge.

Reset
REQ-025 While reset=1 at a clock edge, the following SHALL all clear to 0: state (IDLE), CTRL, PRESET, COUNT, irq_flag.
- Reset SHALL override any simultaneous WE.
REQ-026 After reset, the outputs SHALL be IRQ=0, and Dout=0 for every Addr.
REQ-027 Reset asserted during CNT or INT SHALL abort the count with no IRQ pulse in the following cycle.

Verification
REQ-028 One-shot: PRESET=5, then CTRL=4'b1001 -> IRQ rises 7 edges after the CTRL write; Enable reads 0 afterward; IRQ stays 1 until a CTRL write, then falls.
REQ-029 Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ is a 1-cycle pulse every 5 cycles for at least 4 periods; COUNT sequence repeats 3,2,1,0.
REQ-030 Mask: one-shot expiry with IM=0 -> IRQ=0 and irq_flag=1; then write CTRL IM=1 with Enable=0 -> irq_flag cleared and IRQ stays 0.
REQ-031 Pause: during CNT with COUNT=10, write Enable=0 -> COUNT holds at 9 or 10 and no IRQ occurs; re-enable -> COUNT reloads from PRESET via LOAD.
REQ-032 Edge cases: PRESET=0 one-shot -> IRQ 3 edges after enable. A PRESET write mid-count leaves COUNT unchanged. Writes to Addr 2 and 3 are ignored. Reset mid-CNT -> all registers read 0 and IRQ=0.

Source files
------------

// File: rtl/timer_device.sv
// rtl/timer_device.sv - programmable down-counting timer with masked interrupt request
//
// Purpose: a three-register timer (CTRL, PRESET, COUNT). When enabled, it loads
// PRESET into COUNT and counts down to 0. When it expires, irq_flag is raised.
// One-shot mode then clears Enable. Auto-reload mode reloads and runs again.
//
// Ports:
//   clk   - rising-edge system clock
//   reset - synchronous, active-high; clears every register
//   Addr  - word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused
//   WE    - register write enable for the current cycle
//   Din   - write data
//   Dout  - combinational read data for Addr
//   IRQ   - IM & irq_flag, unregistered
module timer_device #(
  parameter logic [1:0] IDLE = 2'd0,
  parameter logic [1:0] LOAD = 2'd1,
  parameter logic [1:0] CNT  = 2'd2,
  parameter logic [1:0] INT  = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_LOAD = LOAD,
    S_CNT  = CNT,
    S_INT  = INT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        irq_flag;

  logic        flag_set;
  logic        flag_clr;
  logic        en_clr;
  logic        ctrl_we;
  logic        preset_we;
  logic        enable;
  logic        auto_reload;

  assign enable      = ctrl[0];
  // Only Mode = 01 reloads; 10 and 11 behave as one-shot.
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign ctrl_we     = WE && (Addr == 2'd0);
  assign preset_we   = WE && (Addr == 2'd1);
  assign IRQ         = ctrl[3] & irq_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    en_clr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        count_next = preset;
        state_next = S_CNT;
      end
      S_CNT: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (count > 32'd1) begin
          count_next = count - 32'd1;
        end else begin
          // Covers COUNT of 1 and of 0 (PRESET = 0), so COUNT never wraps.
          count_next = '0;
          flag_set   = 1'b1;
          state_next = S_INT;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          flag_clr   = 1'b1;
          state_next = S_LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      count <= count_next;

      // A software CTRL write in the same cycle beats the one-shot Enable clear.
      if (ctrl_we) begin
        ctrl <= Din[3:0];
      end else if (en_clr) begin
        ctrl[0] <= 1'b0;
      end

      if (preset_we) begin
        preset <= Din;
      end

      // An expiry is never lost to a coincident register write.
      if (flag_set) begin
        irq_flag <= 1'b1;
      end else if (flag_clr || ctrl_we || preset_we) begin
        irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    case (Addr)
      2'd0:    Dout = {28'b0, ctrl};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - self-checking bench for timer_device
module tb_timer_device;

  logic        clk;
  logic        reset;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  timer_device dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge; one call = one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = Dout;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] r;
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), r);
      check($sformatf("%s dout addr%0d", tag, a), r, 32'd0);
    end
    check({tag, " irq"}, {31'b0, IRQ}, 32'd0);
  endtask

  // Reference: closed-form timeline measured in edges k after the enabling
  // CTRL write. COUNT first shows PRESET at k=2 and drops by one per edge.
  // Expiry happens at k = 2 + max(N,1). In auto-reload mode the pattern
  // repeats every max(N,1)+2 edges.
  task automatic run_scenario(input logic [1:0] mode, input logic im, input int n, input string tag);
    logic [3:0]  cv;
    logic [31:0] r;
    logic [31:0] exp_count;
    logic        exp_flag;
    logic [3:0]  exp_ctrl;
    logic        auto_m;
    int eff, per, kx, kmax, j;
    apply_reset();
    write_reg(2'd1, 32'(n));
    cv = {im, mode, 1'b1};
    write_reg(2'd0, {28'b0, cv});
    auto_m = (mode == 2'b01);
    eff  = (n < 1) ? 1 : n;
    per  = eff + 2;
    kx   = 2 + eff;
    kmax = auto_m ? 2 + 4 * per : kx + 4;
    for (int k = 1; k <= kmax; k++) begin
      step();
      if (k < 2) begin
        exp_count = 32'd0;
        exp_flag  = 1'b0;
      end else if (auto_m) begin
        j = (k - 2) % per;
        exp_count = (n > j) ? 32'(n - j) : 32'd0;
        exp_flag  = (j == per - 2);
      end else begin
        exp_count = (n > k - 2) ? 32'(n - (k - 2)) : 32'd0;
        exp_flag  = (k >= kx);
      end
      exp_ctrl = (!auto_m && k > kx) ? {im, mode, 1'b0} : cv;
      read_reg(2'd2, r);
      check($sformatf("%s count k=%0d", tag, k), r, exp_count);
      read_reg(2'd0, r);
      check($sformatf("%s ctrl k=%0d", tag, k), r, {28'b0, exp_ctrl});
      check($sformatf("%s irq k=%0d", tag, k), {31'b0, IRQ}, {31'b0, im & exp_flag});
    end
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 2'd0;
    Din   = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Writes to COUNT and the unused word have no effect.
    write_reg(2'd2, 32'd123);
    write_reg(2'd3, 32'd456);
    check_all_zero("ignored_writes");
    write_reg(2'd1, 32'hDEAD_BEEF);
    read_reg(2'd1, r);
    check("preset readback", r, 32'hDEAD_BEEF);
    write_reg(2'd0, 32'hFFFF_FFF6);
    read_reg(2'd0, r);
    check("ctrl upper bits", r, 32'd6);

    // One-shot N=5 with IM: IRQ at edge 7, stays high until a CTRL write.
    run_scenario(2'b00, 1'b1, 5, "oneshot5");
    write_reg(2'd0, 32'd8);
    check("oneshot5 irq after ctrl write", {31'b0, IRQ}, 32'd0);
    read_reg(2'd0, r);
    check("oneshot5 ctrl after write", r, 32'd8);

    run_scenario(2'b01, 1'b1, 3, "auto3");
    run_scenario(2'b00, 1'b1, 0, "preset0");
    run_scenario(2'b11, 1'b1, 2, "mode11");

    // Masked expiry, then setting IM with Enable=0 clears the flag.
    run_scenario(2'b00, 1'b0, 2, "masked");
    write_reg(2'd0, 32'd8);
    check("masked irq after im set", {31'b0, IRQ}, 32'd0);
    step();
    check("masked irq later", {31'b0, IRQ}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_scenario(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 9)), $sformatf("rand%0d", i));
    end

    // Software CTRL write at the one-shot clear edge keeps Enable set.
    apply_reset();
    write_reg(2'd1, 32'd1);
    write_reg(2'd0, 32'd9);
    step(); step(); step();
    check("race irq at expiry", {31'b0, IRQ}, 32'd1);
    write_reg(2'd0, 32'd9);
    read_reg(2'd0, r);
    check("race ctrl kept", r, 32'd9);
    check("race irq cleared", {31'b0, IRQ}, 32'd0);
    step(); step(); step();
    check("race irq reexpiry", {31'b0, IRQ}, 32'd1);

    // PRESET write mid-count leaves COUNT alone; it applies at the next load.
    apply_reset();
    write_reg(2'd1, 32'd10);
    write_reg(2'd0, 32'd9);
    for (int k = 1; k <= 4; k++) step();
    write_reg(2'd1, 32'd50);
    read_reg(2'd2, r);
    check("midpreset count", r, 32'd7);
    for (int k = 6; k <= 11; k++) step();
    check("midpreset irq before", {31'b0, IRQ}, 32'd0);
    step();
    check("midpreset irq expiry", {31'b0, IRQ}, 32'd1);
    write_reg(2'd0, 32'd9);
    step(); step();
    read_reg(2'd2, r);
    check("midpreset reload", r, 32'd50);

    // Pause at COUNT=10, then resume through a reload.
    apply_reset();
    write_reg(2'd1, 32'd20);
    write_reg(2'd0, 32'd9);
    for (int k = 1; k <= 12; k++) step();
    read_reg(2'd2, r);
    check("pause count10", r, 32'd10);
    write_reg(2'd0, 32'd8);
    for (int k = 0; k < 4; k++) begin
      read_reg(2'd2, r);
      check($sformatf("pause hold %0d", k), r, 32'd9);
      check($sformatf("pause irq %0d", k), {31'b0, IRQ}, 32'd0);
      step();
    end
    write_reg(2'd0, 32'd9);
    step();
    read_reg(2'd2, r);
    check("pause during load", r, 32'd9);
    step();
    read_reg(2'd2, r);
    check("pause reloaded", r, 32'd20);

    // Enable cleared while in LOAD: the load completes, then the timer idles.
    apply_reset();
    write_reg(2'd1, 32'd4);
    write_reg(2'd0, 32'd1);
    step();
    write_reg(2'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      read_reg(2'd2, r);
      check($sformatf("loadclr count %0d", k), r, 32'd4);
      step();
    end

    // Reset one edge before an auto-reload expiry, with a coincident write.
    apply_reset();
    write_reg(2'd1, 32'd3);
    write_reg(2'd0, 32'd11);
    for (int k = 1; k <= 4; k++) step();
    read_reg(2'd2, r);
    check("midcnt count before reset", r, 32'd1);
    Addr  = 2'd1;
    Din   = 32'd77;
    WE    = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    WE    = 1'b0;
    check_all_zero("midcnt reset");
    step();
    check_all_zero("midcnt after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
